pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 20'h00000, PC value loaded on reset.
REQ-002 SHALL provide parameter STACK_DEPTH, default 4, return-stack entries; legal range 1..7.
REQ-003 SHALL provide port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port: instr_valid  input  1  op/target/zero_flag are valid this cycle.
REQ-006 SHALL provide port: op  input  3  000 NEXT, 001 JMP, 010 JMPZ, 011 JMPNZ, 100 CALL, 101 RET, 110 HALT, 111 reserved.
REQ-007 SHALL provide port: target  input  20  jump/call destination address.
REQ-008 SHALL provide port: zero_flag  input  1  ALU zero flag for the current instruction.
REQ-009 SHALL provide port: stall  input  1  freeze request from downstream.
REQ-010 SHALL provide port: pc  output  20  registered program counter.
REQ-011 SHALL provide port: flush  output  1  one-cycle pulse after a taken redirect.
REQ-012 SHALL provide port: halted  output  1  sequencer in HALT state.
REQ-013 SHALL provide port: error  output  1  sticky stack overflow/underflow flag.
REQ-014 SHALL provide port: sp  output  3  current return-stack occupancy.

Function
REQ-015 SHALL implement a two-state FSM, RUN and HALT; HALT is left only by rst.
REQ-016 In RUN with instr_valid=1 and stall=0, pc SHALL update on the next edge per op; otherwise pc holds.
REQ-017 stall SHALL take priority over instr_valid: no pc, stack, or state change while stall=1.
REQ-018 NEXT and reserved op 111 SHALL load pc+1, modulo 2^20 (20'hFFFFF wraps to 20'h00000).
REQ-019 JMP SHALL load target unconditionally.
REQ-020 JMPZ SHALL load target if zero_flag=1, else pc+1; JMPNZ SHALL load target if zero_flag=0, else pc+1.
REQ-021 CALL SHALL push pc+1 (wrapped), increment sp, and load target.
REQ-022 RET SHALL pop the top entry into pc and decrement sp.
REQ-023 HALT op SHALL hold pc and move the FSM to HALT.
REQ-024 CALL with sp=STACK_DEPTH SHALL not push and not jump, SHALL set error, and SHALL move the FSM to HALT.
REQ-025 RET with sp=0 SHALL hold pc, SHALL set error, and SHALL move the FSM to HALT.
REQ-026 flush SHALL be 1 for exactly the cycle after any update that loads a value other than pc+1 (taken JMP/JMPZ/JMPNZ/CALL/RET), else 0.
REQ-027 In HALT, all inputs except rst SHALL be ignored; halted=1 and flush=0.
REQ-028 error SHALL remain 1 until rst once set.

Reset
REQ-029 On rst=1 at a clock edge: pc=RESET_PC, sp=0, flush=0, halted=0, error=0, FSM=RUN; stack contents don't-care.
REQ-030 rst SHALL override every other input in the same cycle, including mid-stall and in HALT.

Configuration
REQ-031 With macro PC_RET_STACK_EN defined, CALL/RET, the stack, sp, and the stack error paths SHALL be implemented as specified.
REQ-032 Without PC_RET_STACK_EN, CALL SHALL behave as JMP, RET as NEXT, sp SHALL be tied to 0, and error SHALL be tied to 0.

Verification
REQ-033 rst; NEXT x3 -> pc 0,1,2,3; flush stays 0.
REQ-034 pc=0x00010; JMPZ target 0xABCDE with zero_flag=1 -> pc=0xABCDE, flush=1 for one cycle; same op with zero_flag=0 -> pc=0x00011, flush=0.
REQ-035 JMP target 0xFFFFF then NEXT -> pc=0x00000 (wrap); stall=1 with JMP 0x12345 -> pc holds 0x00000.
REQ-036 Macro defined: CALL 0x00100 at pc=0x00020 -> pc=0x00100, sp=1; RET -> pc=0x00021, sp=0.
REQ-037 STACK_DEPTH=4: five CALLs -> fifth leaves pc unchanged, error=1, halted=1; a further JMP is ignored; rst -> pc=RESET_PC, error=0.
REQ-038 RET at sp=0 -> error=1, halted=1; macro undefined: same RET -> pc+1, error=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional branches and an optional return stack.
// Define PC_RET_STACK_EN to build CALL/RET with the return stack; otherwise CALL acts as JMP and RET as NEXT.
module pc_sequencer #(
    parameter logic [19:0] RESET_PC    = 20'h00000,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [2:0]  op,
    input  logic [19:0] target,
    input  logic        zero_flag,
    input  logic        stall,
    output logic [19:0] pc,
    output logic        flush,
    output logic        halted,
    output logic        error,
    output logic [2:0]  sp
);

    typedef enum logic {RUN, HALT} state_t;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'b000,
        OP_JMP   = 3'b001,
        OP_JMPZ  = 3'b010,
        OP_JMPNZ = 3'b011,
        OP_CALL  = 3'b100,
        OP_RET   = 3'b101,
        OP_HALT  = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    state_t      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [19:0] pc_inc;
    logic        advance;

    assign pc_inc  = pc_q + 20'd1;
    assign advance = (state_q == RUN) && instr_valid && !stall;

`ifdef PC_RET_STACK_EN
    logic [2:0]  sp_q, sp_d;
    logic        err_q, err_d;
    logic        push_en;
    logic [19:0] stack_top;
    logic [19:0] stack_q [STACK_DEPTH];

    // Entry sp-1 is the top of stack; index by compare to keep the 3-bit sp width-clean.
    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == 3'(i + 1)) stack_top = stack_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == 3'(i)) stack_q[i] <= pc_inc;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
`ifdef PC_RET_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
`endif
        if (advance) begin
            case (op_t'(op))
                OP_JMP: begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end
                OP_JMPZ: begin
                    pc_d    = zero_flag ? target : pc_inc;
                    flush_d = zero_flag;
                end
                OP_JMPNZ: begin
                    pc_d    = zero_flag ? pc_inc : target;
                    flush_d = !zero_flag;
                end
`ifdef PC_RET_STACK_EN
                OP_CALL: begin
                    if (sp_q == 3'(STACK_DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + 3'd1;
                        pc_d    = target;
                        flush_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (sp_q == 3'd0) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        sp_d    = sp_q - 3'd1;
                        pc_d    = stack_top;
                        flush_d = 1'b1;
                    end
                end
`else
                OP_CALL: begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end
`endif
                OP_HALT: state_d = HALT;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
`ifdef PC_RET_STACK_EN
            sp_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
`ifdef PC_RET_STACK_EN
            sp_q    <= sp_d;
            err_q   <= err_d;
`endif
        end
    end

    assign pc     = pc_q;
    assign flush  = flush_q;
    assign halted = (state_q == HALT);
`ifdef PC_RET_STACK_EN
    assign sp     = sp_q;
    assign error  = err_q;
`else
    assign sp     = '0;
    assign error  = 1'b0;
`endif

endmodule
